// File: rtl/alu_chk_pkg.sv
// Shared types and default sizing for the ALU response checker.
// Optional feature macro: CHECKER_MASK_EN (per-entry compare mask).
package alu_chk_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned DEPTH_DEF = 8;
  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chk_state_e;

endpackage

// File: rtl/alu_response_checker_chk_fifo.sv
// Synchronous FIFO holding expected-result entries; head is always visible.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module chk_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push;
  logic             w_pop;

  assign empty  = (r_wr_ptr == r_rd_ptr);
  assign full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                  (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign head   = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update: reset/clear to empty, otherwise advance on push/pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (w_push && !clr) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/alu_response_checker.sv
// In-order response checker: queues expected words, compares DUT results
// against the FIFO head, and keeps saturating pass/fail stats plus the
// first mismatch. CHECKER_MASK_EN adds a per-entry compare mask (exp_mask).
module alu_response_checker
  import alu_chk_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             finish,
  input  logic             exp_valid,
  output logic             exp_ready,
  input  logic [WIDTH-1:0] exp_data,
`ifdef CHECKER_MASK_EN
  input  logic [WIDTH-1:0] exp_mask,
`endif
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [WIDTH-1:0] res_data,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [WIDTH-1:0] first_fail_exp,
  output logic [WIDTH-1:0] first_fail_got,
  output logic             busy,
  output logic             done
);

`ifdef CHECKER_MASK_EN
  localparam int unsigned EW = 2 * WIDTH;
`else
  localparam int unsigned EW = WIDTH;
`endif

  chk_state_e       r_state;
  chk_state_e       w_next;
  logic             w_start_go;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [EW-1:0]    w_entry;
  logic [EW-1:0]    w_head;
  logic [WIDTH-1:0] w_head_data;
  logic [WIDTH-1:0] w_head_mask;
  logic [WIDTH-1:0] w_exp_rep;
  logic             w_match;

  logic [CNT_W-1:0] r_pass;
  logic [CNT_W-1:0] r_fail;
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] r_ff_idx;
  logic [WIDTH-1:0] r_ff_exp;
  logic [WIDTH-1:0] r_ff_got;
  logic             r_busy;
  logic             r_done;

`ifdef CHECKER_MASK_EN
  assign w_entry     = {exp_mask, exp_data};
  assign w_head_data = w_head[WIDTH-1:0];
  assign w_head_mask = w_head[EW-1:WIDTH];
`else
  assign w_entry     = exp_data;
  assign w_head_data = w_head;
  assign w_head_mask = '1;
`endif

  assign w_exp_rep = w_head_data & w_head_mask;
  assign w_match   = (((res_data ^ w_head_data) & w_head_mask) == '0);

  assign exp_ready = (r_state == RUN) && !w_full;
  assign res_ready = ((r_state == RUN) || (r_state == DRAIN)) && !w_empty;
  assign w_push    = exp_valid && exp_ready;
  assign w_pop     = res_valid && res_ready;

  chk_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_start_go),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (w_entry),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_head)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode; start is only honoured from IDLE or DONE.
  always_comb begin
    w_next     = r_state;
    w_start_go = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_next     = RUN;
          w_start_go = 1'b1;
        end
      end
      RUN:     if (finish)  w_next = DRAIN;
      DRAIN:   if (w_empty) w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  // Compare statistics: saturating counters and first-mismatch capture.
  always_ff @(posedge clk) begin
    if (!rst_n || w_start_go) begin
      r_pass   <= '0;
      r_fail   <= '0;
      r_idx    <= '0;
      r_ff_idx <= '0;
      r_ff_exp <= '0;
      r_ff_got <= '0;
    end else if (w_pop) begin
      if (r_idx != '1) r_idx <= r_idx + CNT_W'(1);
      if (w_match) begin
        if (r_pass != '1) r_pass <= r_pass + CNT_W'(1);
      end else begin
        if (r_fail != '1) r_fail <= r_fail + CNT_W'(1);
        if (r_fail == '0) begin
          r_ff_idx <= r_idx;
          r_ff_exp <= w_exp_rep;
          r_ff_got <= res_data;
        end
      end
    end
  end

  // Registered status flags tracking the state being entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next == RUN) || (w_next == DRAIN);
      r_done <= (w_next == DONE);
    end
  end

  assign pass_cnt       = r_pass;
  assign fail_cnt       = r_fail;
  assign first_fail_idx = r_ff_idx;
  assign first_fail_exp = r_ff_exp;
  assign first_fail_got = r_ff_got;
  assign busy           = r_busy;
  assign done           = r_done;

endmodule

// File: tb/tb_alu_response_checker.sv
// Directed + light random bench for alu_response_checker with a queue-based
// scoreboard model. Define CHECKER_MASK_EN to also exercise the masked compare.
module tb_alu_response_checker;

  localparam int unsigned W = 32;
  localparam int unsigned D = 8;
  localparam int unsigned C = 16;

  logic         clk = 1'b0;
  logic         rst_n, start, finish, exp_valid, res_valid;
  logic [W-1:0] exp_data, exp_mask, res_data;
  logic         exp_ready, res_ready;
  logic [C-1:0] pass_cnt, fail_cnt, first_fail_idx;
  logic [W-1:0] first_fail_exp, first_fail_got;
  logic         busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard model
  int           m_state;
  logic [W-1:0] m_qd[$];
  logic [W-1:0] m_qm[$];
  logic [C-1:0] m_pass, m_fail, m_idx, m_fidx;
  logic [W-1:0] m_fexp, m_fgot;
  logic         o_er, o_rr;

  always #5 clk = ~clk;

  alu_response_checker #(.WIDTH(W), .DEPTH(D), .CNT_W(C)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .finish         (finish),
    .exp_valid      (exp_valid),
    .exp_ready      (exp_ready),
    .exp_data       (exp_data),
`ifdef CHECKER_MASK_EN
    .exp_mask       (exp_mask),
`endif
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_data       (res_data),
    .pass_cnt       (pass_cnt),
    .fail_cnt       (fail_cnt),
    .first_fail_idx (first_fail_idx),
    .first_fail_exp (first_fail_exp),
    .first_fail_got (first_fail_got),
    .busy           (busy),
    .done           (done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    m_qd.delete();
    m_qm.delete();
    m_pass = '0; m_fail = '0; m_idx = '0;
    m_fidx = '0; m_fexp = '0; m_fgot = '0;
  endtask

  // One clock cycle: drive, check handshakes, advance model, check stats.
  task automatic step(input logic rn, input logic s, input logic f,
                      input logic ev, input logic [W-1:0] ed, input logic [W-1:0] em,
                      input logic rv, input logic [W-1:0] rd);
    logic e_er, e_rr, acc_e, acc_r;
    int sz;
    logic [W-1:0] hd, hm;
    rst_n = rn; start = s; finish = f;
    exp_valid = ev; exp_data = ed; exp_mask = em;
    res_valid = rv; res_data = rd;
    #1;
    sz   = m_qd.size();
    e_er = (m_state == 1) && (sz < int'(D));
    e_rr = ((m_state == 1) || (m_state == 2)) && (sz > 0);
    o_er = exp_ready;
    o_rr = res_ready;
    chk("exp_ready", 64'(exp_ready), 64'(e_er));
    chk("res_ready", 64'(res_ready), 64'(e_rr));
    acc_e = ev && e_er;
    acc_r = rv && e_rr;
    @(posedge clk);
    if (!rn) begin
      model_clear();
      m_state = 0;
    end else if (s && (m_state == 0 || m_state == 3)) begin
      model_clear();
      m_state = 1;
    end else begin
      if (acc_r) begin
        hd = m_qd.pop_front();
        hm = m_qm.pop_front();
        if (((rd ^ hd) & hm) == '0) begin
          if (m_pass != {C{1'b1}}) m_pass = m_pass + 1'b1;
        end else begin
          if (m_fail == '0) begin
            m_fidx = m_idx;
            m_fexp = hd & hm;
            m_fgot = rd;
          end
          if (m_fail != {C{1'b1}}) m_fail = m_fail + 1'b1;
        end
        if (m_idx != {C{1'b1}}) m_idx = m_idx + 1'b1;
      end
      if (acc_e) begin
        m_qd.push_back(ed);
`ifdef CHECKER_MASK_EN
        m_qm.push_back(em);
`else
        m_qm.push_back('1);
`endif
      end
      if (m_state == 1 && f)             m_state = 2;
      else if (m_state == 2 && sz == 0)  m_state = 3;
    end
    #1;
    chk("pass_cnt",       64'(pass_cnt),       64'(m_pass));
    chk("fail_cnt",       64'(fail_cnt),       64'(m_fail));
    chk("first_fail_idx", 64'(first_fail_idx), 64'(m_fidx));
    chk("first_fail_exp", 64'(first_fail_exp), 64'(m_fexp));
    chk("first_fail_got", 64'(first_fail_got), 64'(m_fgot));
    chk("busy",           64'(busy), 64'((m_state == 1) || (m_state == 2)));
    chk("done",           64'(done), 64'(m_state == 3));
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, '1, 1'b0, '0);
  endtask
  task automatic go();
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, '1, 1'b0, '0);
  endtask
  task automatic fin();
    step(1'b1, 1'b0, 1'b1, 1'b0, '0, '1, 1'b0, '0);
  endtask
  task automatic push(input logic [W-1:0] d);
    step(1'b1, 1'b0, 1'b0, 1'b1, d, '1, 1'b0, '0);
  endtask
  task automatic res(input logic [W-1:0] d);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, '1, 1'b1, d);
  endtask

  initial begin
    logic         r_ev, r_rv;
    logic [W-1:0] r_ed, r_rd;
    m_state = 0;
    model_clear();
    rst_n = 1'b0; start = 1'b0; finish = 1'b0;
    exp_valid = 1'b0; res_valid = 1'b0;
    exp_data = '0; exp_mask = '1; res_data = '0;
    @(posedge clk); #1;

    // Reset
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, '1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h1, '1, 1'b1, 32'h1);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_pass", 64'(pass_cnt), 64'(0));
    idle();
    chk("idle_exp_ready", 64'(o_er), 64'(0));

    // Test 1: two matching results
    go();
    push(32'hFFFF_FFFF);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0003_FFFF, '1, 1'b1, 32'hFFFF_FFFF);
    res(32'h0003_FFFF);
    fin();
    idle();
    chk("t1_pass", 64'(pass_cnt), 64'(2));
    chk("t1_fail", 64'(fail_cnt), 64'(0));
    chk("t1_done", 64'(done), 64'(1));

    // Test 2: first mismatch capture
    go();
    chk("t2_cleared", 64'(pass_cnt), 64'(0));
    push(32'hFFFF_FFFF);
    push(32'hFFFF_FFFF);
    push(32'hFFFF_FFFF);
    res(32'hFFFF_FFFF);
    res(32'h0000_FFFF);
    res(32'h0000_0000);
    fin();
    idle();
    chk("t2_pass", 64'(pass_cnt), 64'(1));
    chk("t2_fail", 64'(fail_cnt), 64'(2));
    chk("t2_idx",  64'(first_fail_idx), 64'(1));
    chk("t2_exp",  64'(first_fail_exp), 64'(32'hFFFF_FFFF));
    chk("t2_got",  64'(first_fail_got), 64'(32'h0000_FFFF));

    // Test 3: full FIFO refuses push even with a same-cycle pop
    go();
    for (int i = 0; i < int'(D); i++) push(W'(i + 16));
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, '1, 1'b1, 32'h10);
    chk("t3_full_exp_ready", 64'(o_er), 64'(0));
    chk("t3_full_res_ready", 64'(o_rr), 64'(1));
    idle();
    chk("t3_after_exp_ready", 64'(o_er), 64'(1));
    fin();
    for (int i = 1; i < int'(D); i++) res(W'(i + 16));
    idle();
    chk("t3_pass", 64'(pass_cnt), 64'(D));
    chk("t3_done", 64'(done), 64'(1));

    // Test 4: result held against empty FIFO; no bypass on push
    go();
    res(32'h55);
    res(32'h55);
    chk("t4_empty_res_ready", 64'(o_rr), 64'(0));
    chk("t4_no_count", 64'(pass_cnt + fail_cnt), 64'(0));
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h55, '1, 1'b1, 32'h55);
    chk("t4_push_cycle_res_ready", 64'(o_rr), 64'(0));
    res(32'h55);
    chk("t4_next_res_ready", 64'(o_rr), 64'(1));
    chk("t4_pass", 64'(pass_cnt), 64'(1));

    // Test 5: reset mid-run discards stats
    push(32'h1);
    res(32'h2);
    chk("t5_fail_before", 64'(fail_cnt), 64'(1));
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, '1, 1'b0, '0);
    chk("t5_busy", 64'(busy), 64'(0));
    chk("t5_fail", 64'(fail_cnt), 64'(0));
    chk("t5_got",  64'(first_fail_got), 64'(0));
    idle();

    // Random mixed traffic with occasional mismatches
    go();
    for (int i = 0; i < 60; i++) begin
      r_ev = 1'($urandom % 2);
      r_rv = 1'($urandom % 2);
      r_ed = $urandom;
      if (m_qd.size() > 0) r_rd = (($urandom % 4) == 0) ? (m_qd[0] ^ 32'h1) : m_qd[0];
      else                 r_rd = $urandom;
      step(1'b1, 1'b0, 1'b0, r_ev, r_ed, '1, r_rv, r_rd);
    end
    fin();
    for (int i = 0; i < 2 * int'(D) + 4; i++) begin
      if (m_state == 3) break;
      res((m_qd.size() > 0) ? m_qd[0] : '0);
    end
    chk("rand_done", 64'(done), 64'(1));

`ifdef CHECKER_MASK_EN
    // Test 6: masked compare
    go();
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h1234_ABCD, 32'h0000_FFFF, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h1234_ABCD, 32'h0000_FFFF, 1'b1, 32'hFFFF_ABCD);
    res(32'h1234_ABCE);
    chk("t6_pass", 64'(pass_cnt), 64'(1));
    chk("t6_fail", 64'(fail_cnt), 64'(1));
    chk("t6_exp",  64'(first_fail_exp), 64'(32'h0000_ABCD));
    chk("t6_got",  64'(first_fail_got), 64'(32'h1234_ABCE));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
